// File: rtl/onehot_strobe_3to8.sv
// One-hot strobe generator: a 3-bit code selects one of eight output lines,
// which is driven for (len+1) cycles, followed by a fixed idle gap.
// Every output is decoded from registered state, so nothing combinational
// leaks from the request inputs to the outputs.
module onehot_strobe_3to8 #(
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_code,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic             done,
  output logic [7:0]       acc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Gap counter is loaded with GAP-1 and counts down to zero; guarded so
  // GAP=0 does not produce a negative load value.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t             state_reg, state_next;
  logic [2:0]         code_reg,  code_next;
  logic [LEN_W-1:0]   cnt_reg,   cnt_next;
  logic [3:0]         gap_reg,   gap_next;
  logic [7:0]         acc_reg,   acc_next;

  // Next-state logic: accept only in IDLE, count down DRIVE, then the gap.
  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    acc_next   = acc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_DRIVE;
          code_next  = in_code;
          cnt_next   = in_len;
          acc_next   = acc_reg + 8'd1;
        end
      end
      ST_DRIVE: begin
        if (cnt_reg == '0) begin
          if (GAP > 0) begin
            state_next = ST_GAP;
            gap_next   = GAP_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset wins over any simultaneous request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      code_reg  <= 3'd0;
      cnt_reg   <= '0;
      gap_reg   <= 4'd0;
      acc_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      acc_reg   <= acc_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DRIVE);
  assign done      = out_valid && (cnt_reg == '0);
  assign acc_cnt   = acc_reg;

  // One comparator per line: only the selected line can be high, and only
  // while driving, so the output is zero or one-hot by construction.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      assign out[gi] = out_valid && (code_reg == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_onehot_strobe_3to8.sv
// Bench for onehot_strobe_3to8: a directed vector table, a code sweep and
// random traffic against a timeline model on a GAP=1 instance, plus a
// back-to-back wrap run on a GAP=0 instance.
module tb_onehot_strobe_3to8;

  localparam int GAP_A = 1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // GAP=1 instance
  logic       rst = 1'b1;
  logic [2:0] in_code = 3'd0;
  logic [3:0] in_len = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       done;
  logic [7:0] acc_cnt;

  // GAP=0 instance
  logic       g0_rst = 1'b1;
  logic [2:0] g0_code = 3'd0;
  logic [3:0] g0_len = 4'd0;
  logic       g0_valid = 1'b0;
  logic       g0_ready;
  logic [7:0] g0_out;
  logic       g0_out_valid;
  logic       g0_done;
  logic [7:0] g0_acc;

  onehot_strobe_3to8 #(.LEN_W(4), .GAP(GAP_A)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .done(done), .acc_cnt(acc_cnt)
  );

  onehot_strobe_3to8 #(.LEN_W(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst(g0_rst), .in_code(g0_code), .in_len(g0_len),
    .in_valid(g0_valid), .in_ready(g0_ready), .out(g0_out),
    .out_valid(g0_out_valid), .done(g0_done), .acc_cnt(g0_acc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a strobe accepted at edge t with length L drives in
  // cycles t..t+L, fires done at t+L, and the block is free again at
  // t+L+GAP+1. Cycle n means the interval after the n-th rising edge.
  int       cyc = 0;
  int       acc_t = 0;
  int       free_at = 0;
  int       m_len = 0;
  int       m_code = 0;
  bit       m_active = 0;
  int       m_acc = 0;

  task automatic check_model();
    logic [7:0] e_out;
    logic       e_done;
    bit         in_win;
    in_win = m_active && (cyc >= acc_t) && (cyc <= acc_t + m_len);
    e_out  = in_win ? (8'd1 << m_code) : 8'd0;
    e_done = m_active && (cyc == acc_t + m_len);
    chk("m_out", {24'd0, out}, {24'd0, e_out});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, in_win});
    chk("m_done", {31'd0, done}, {31'd0, e_done});
    chk("m_ready", {31'd0, in_ready}, {31'd0, (cyc >= free_at)});
    chk("m_acc", {24'd0, acc_cnt}, m_acc[31:0]);
    chk("onehot0", {31'd0, $onehot0(out)}, 32'd1);
    chk("valid_iff_out", {31'd0, out_valid}, {31'd0, (out != 8'd0)});
  endtask

  // Apply inputs, advance the model for the coming edge, clock, sample.
  task automatic step(input logic r, input logic v, input logic [2:0] c, input logic [3:0] l);
    rst = r; in_valid = v; in_code = c; in_len = l;
    if (r) begin
      m_active = 0;
      free_at  = cyc + 1;
      m_acc    = 0;
    end else if (v && (cyc >= free_at)) begin
      m_active = 1;
      acc_t    = cyc + 1;
      m_code   = int'(c);
      m_len    = int'(l);
      free_at  = acc_t + m_len + GAP_A + 1;
      m_acc    = (m_acc + 1) % 256;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [2:0] c;
    logic [3:0] l;
    logic [7:0] o;
    logic       ov;
    logic       d;
    logic       rdy;
    logic [7:0] a;
  } vec_t;

  vec_t tbl[16];

  initial begin
    //            r  v  code  len    out    ov d  rdy acc
    tbl[0]  = '{1'b1,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b1,8'd0}; // reset
    tbl[1]  = '{1'b0,1'b1,3'd5,4'd0, 8'h20,1'b1,1'b1,1'b0,8'd1}; // single-cycle strobe
    tbl[2]  = '{1'b0,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b0,8'd1}; // gap
    tbl[3]  = '{1'b0,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b1,8'd1}; // idle
    tbl[4]  = '{1'b0,1'b1,3'd0,4'd3, 8'h01,1'b1,1'b0,1'b0,8'd2}; // 4-cycle strobe
    tbl[5]  = '{1'b0,1'b1,3'd7,4'd3, 8'h01,1'b1,1'b0,1'b0,8'd2}; // ignored request
    tbl[6]  = '{1'b0,1'b1,3'd2,4'd9, 8'h01,1'b1,1'b0,1'b0,8'd2};
    tbl[7]  = '{1'b0,1'b0,3'd0,4'd0, 8'h01,1'b1,1'b1,1'b0,8'd2}; // done on 4th
    tbl[8]  = '{1'b0,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b0,8'd2};
    tbl[9]  = '{1'b0,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b1,8'd2};
    tbl[10] = '{1'b0,1'b1,3'd3,4'd5, 8'h08,1'b1,1'b0,1'b0,8'd3}; // len=5 strobe
    tbl[11] = '{1'b1,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b1,8'd0}; // reset mid-drive
    tbl[12] = '{1'b0,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b1,8'd0};
    tbl[13] = '{1'b1,1'b1,3'd2,4'd1, 8'h00,1'b0,1'b0,1'b1,8'd0}; // reset beats accept
    tbl[14] = '{1'b0,1'b0,3'd0,4'd0, 8'h00,1'b0,1'b0,1'b1,8'd0};
    tbl[15] = '{1'b0,1'b1,3'd6,4'd15,8'h40,1'b1,1'b0,1'b0,8'd1}; // max length

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].l);
      chk($sformatf("vec%0d_out", i), {24'd0, out}, {24'd0, tbl[i].o});
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, tbl[i].d});
      chk($sformatf("vec%0d_rdy", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("vec%0d_acc", i), {24'd0, acc_cnt}, {24'd0, tbl[i].a});
      $display("vec %0d: out=%02h ov=%0b done=%0b rdy=%0b acc=%0d",
               i, out, out_valid, done, in_ready, acc_cnt);
    end

    // Let the max-length strobe run out while in_valid stays high with
    // changing codes; the model predicts exactly one extra accept.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 3'(i), 4'd1);
      $display("hold %0d: out=%02h rdy=%0b acc=%0d", i, out, in_ready, acc_cnt);
    end

    // Code sweep: each code produces its own line.
    for (int code = 0; code < 8; code++) begin
      for (int w = 0; w < 40 && cyc < free_at; w++) step(1'b0, 1'b0, 3'd0, 4'd0);
      chk("sweep_wait", {31'd0, (cyc >= free_at)}, 32'd1);
      step(1'b0, 1'b1, 3'(code), 4'd0);
      chk($sformatf("sweep%0d", code), {24'd0, out}, {24'd0, 8'd1 << code});
      $display("sweep code=%0d out=%02h", code, out);
    end

    // Random traffic against the timeline model.
    for (int i = 0; i < 800; i++) begin
      logic       r;
      logic       v;
      logic [3:0] l;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       l = 4'd0;
        1:       l = 4'd15;
        default: l = 4'($urandom_range(0, 15));
      endcase
      step(r, v, 3'($urandom_range(0, 7)), l);
      $display("rand %0d: r=%0b v=%0b out=%02h done=%0b rdy=%0b acc=%0d",
               i, r, v, out, done, in_ready, acc_cnt);
    end
    rst = 1'b1;

    // GAP=0: held request with len=0 strobes every other cycle; after
    // 256 accepts the counter is back at zero.
    @(posedge clk);
    @(negedge clk);
    chk("g0_reset_rdy", {31'd0, g0_ready}, 32'd1);
    chk("g0_reset_acc", {24'd0, g0_acc}, 32'd0);
    g0_rst = 1'b0; g0_valid = 1'b1; g0_len = 4'd0;
    for (int k = 1; k <= 512; k++) begin
      bit odd;
      g0_code = 3'(k % 8);
      @(posedge clk);
      @(negedge clk);
      odd = (k % 2) == 1;
      chk("g0_valid", {31'd0, g0_out_valid}, {31'd0, odd});
      chk("g0_out", {24'd0, g0_out}, odd ? 32'(8'd1 << (k % 8)) : 32'd0);
      chk("g0_done", {31'd0, g0_done}, {31'd0, odd});
      chk("g0_rdy", {31'd0, g0_ready}, {31'd0, !odd});
      chk("g0_acc", {24'd0, g0_acc}, 32'(((k + 1) / 2) % 256));
      chk("g0_onehot0", {31'd0, $onehot0(g0_out)}, 32'd1);
      if (k % 64 == 0) $display("g0 cycle %0d: acc=%0d", k, g0_acc);
    end
    chk("g0_wrap", {24'd0, g0_acc}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_3to8.md
ONEHOT_STROBE_3TO8 -- requirements
Module: onehot_strobe_3to8

Interface
REQ-001 Parameter: LEN_W, default 4, width of the drive-length field.
REQ-002 Parameter: GAP, default 1, idle cycles forced after each strobe; legal range 0..15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: in_code  input  3  binary index of the output line to strobe.
REQ-006 Port: in_len  input  LEN_W  drive length minus one, in cycles.
REQ-007 Port: in_valid  input  1  request present.
REQ-008 Port: in_ready  output  1  block can accept a request this cycle.
REQ-009 Port: out  output  8  one-hot strobe lines.
REQ-010 Port: out_valid  output  1  out currently carries a strobe.
REQ-011 Port: done  output  1  high during the final drive cycle of a strobe.
REQ-012 Port: acc_cnt  output  8  count of accepted requests.

Function
REQ-013 The block shall implement states IDLE, DRIVE, GAP; all outputs shall derive from registered state only.
REQ-014 in_ready shall be 1 in IDLE and 0 in DRIVE and GAP.
REQ-015 A request shall be accepted on a rising edge where in_valid=1 and in_ready=1; in_valid in any other cycle shall be ignored.
REQ-016 On accept: in_code and in_len captured; down-counter loaded with in_len; state -> DRIVE; acc_cnt increments.
REQ-017 Latency: out and out_valid shall reflect the request in the cycle immediately after the accepting edge.
REQ-018 In DRIVE: out = 8'b1 shifted left by the captured code; out_valid=1; counter decrements each cycle.
REQ-019 DRIVE shall last exactly in_len+1 cycles; in_len=0 gives a single-cycle strobe; in_len=2^LEN_W-1 gives 2^LEN_W cycles.
REQ-020 done = 1 exactly when state=DRIVE and counter=0; one pulse per request.
REQ-021 From the final DRIVE cycle: next state GAP if GAP>0, else IDLE.
REQ-022 GAP shall last exactly GAP cycles with out=8'h00, out_valid=0, then -> IDLE.
REQ-023 In IDLE and GAP, out shall be 8'h00 and out_valid 0.
REQ-024 out shall always be 8'h00 or exactly one bit set; never multi-hot.
REQ-025 Changes on in_code/in_len/in_valid during DRIVE or GAP shall not affect out, the counter, or acc_cnt.
REQ-026 With GAP=0, back-to-back requests shall yield a minimum period of in_len+2 cycles (one IDLE cycle between strobes).
REQ-027 acc_cnt shall wrap from 8'hFF to 8'h00 with no other effect.

Reset
REQ-028 With rst=1 at a rising edge: state -> IDLE; out=8'h00; out_valid=0; done=0; counter=0; acc_cnt=8'h00; in_ready=1 in the following cycle.
REQ-029 rst shall take priority over a simultaneous accept; the request shall be dropped and acc_cnt not incremented.
REQ-030 rst asserted mid-DRIVE or mid-GAP shall abort the strobe with no done pulse.

Verification
REQ-031 GAP=1: code=3'd5, len=0, valid one cycle -> next cycle out=8'h20, out_valid=1, done=1; then 1 GAP cycle out=0; then in_ready=1; acc_cnt=1.
REQ-032 code=3'd0, len=3 -> out=8'h01 for exactly 4 cycles, done only on the 4th; codes 0..7 sweep gives out=8'h01..8'h80.
REQ-033 Hold in_valid=1 with changing in_code during DRIVE -> out unchanged, acc_cnt +1 only; the next accept occurs on the first IDLE cycle.
REQ-034 rst on 2nd cycle of a len=5 strobe -> out=8'h00, no done, acc_cnt=0, in_ready=1 in the cycle after reset.
REQ-035 GAP=0, in_valid held high, len=0 -> strobes every 2 cycles; 256 accepts -> acc_cnt wraps to 8'h00.
REQ-036 Every cycle of every test: out is zero or one-hot; out_valid=1 iff out≠0.
